// File: rtl/receiver_pkg.sv
// receiver_pkg: shared UART state encoding, sampling constants and stop-bit codes
package receiver_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int OVERSAMPLE = 16;
  localparam logic [4:0] MID_SAMPLE = 5'd7;
  localparam logic [4:0] LAST_SAMPLE = 5'd15;
  localparam logic [1:0] STOP_1 = 2'b00;
  localparam logic [1:0] STOP_1_ALT = 2'b01;
  localparam logic [1:0] STOP_1_5 = 2'b10;
  localparam logic [1:0] STOP_2 = 2'b11;
  function automatic logic [3:0] eff_len(input logic [3:0] l);
    return (l >= 4'd6 && l <= 4'd9) ? l : 4'd9;
  endfunction
endpackage

// File: rtl/receiver_rx_sync.sv
// receiver_rx_sync: two-flop synchronizer for the RX line plus falling-edge detect
module receiver_rx_sync (
  input  logic baud_clock,
  input  logic reset,
  input  logic d,
  output logic rxs,
  output logic fall
);
  logic s1, prev;
  // idle-high line: all stages reset to 1 so reset never looks like a start edge
  always_ff @(posedge baud_clock or negedge reset)
    if (!reset) {s1, rxs, prev} <= 3'b111;
    else {s1, rxs, prev} <= {d, s1, rxs};
  assign fall = prev && !rxs;
endmodule

// File: rtl/receiver.sv
// receiver: 16x-oversampled UART RX with held output word, valid/ack handshake and RTS
module receiver
  import receiver_pkg::*;
(
  input  logic       baud_clock,
  input  logic       reset,
  input  logic       serial_data_in,
  input  logic [3:0] data_length,
  input  logic [1:0] num_stop_bit,
  input  logic       MCR1,
  input  logic       data_ack,
  output logic [8:0] data_out,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       n_RTS
);
  state_t state;
  logic [4:0] cnt;
  logic [3:0] bit_cnt;
  logic [8:0] sh;
  logic stop_bad, rxs, fall, last, commit, take, rv_n;
  logic [3:0] n;

  receiver_rx_sync u_sync (.baud_clock(baud_clock), .reset(reset), .d(serial_data_in), .rxs(rxs), .fall(fall));

  assign n = eff_len(data_length);
  assign last = cnt == LAST_SAMPLE;
  // final stop sample: the second one in two-stop mode, otherwise the first
  assign commit = MCR1 && state == STOP && last && (num_stop_bit != STOP_2 || bit_cnt == 4'd1);
  assign take = commit && (!rx_valid || data_ack);
  assign rv_n = take || (rx_valid && !data_ack);

  // frame FSM plus output word, handshake and error flags
  always_ff @(posedge baud_clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      stop_bad <= 1'b0;
      data_out <= '0;
      rx_valid <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      n_RTS <= 1'b1;
    end else begin
      rx_valid <= rv_n;
      n_RTS <= !(MCR1 && !rv_n);
      if (take) begin
        data_out <= sh;
        framing_error <= stop_bad || !rxs;
      end
      if (commit && !take) overrun_error <= 1'b1;
      else if (data_ack) overrun_error <= 1'b0;
      if (!MCR1) begin
        state <= IDLE;
        cnt <= '0;
        bit_cnt <= '0;
      end else begin
        cnt <= cnt + 5'd1;
        case (state)
          IDLE: begin
            cnt <= '0;
            if (fall) state <= START;
          end
          START: if (cnt == MID_SAMPLE) begin
            cnt <= '0;
            bit_cnt <= '0;
            sh <= '0;
            stop_bad <= 1'b0;
            state <= rxs ? IDLE : DATA;
          end
          DATA: if (last) begin
            cnt <= '0;
            if (bit_cnt == n - 4'd1) begin
              sh[8] <= rxs;
              bit_cnt <= '0;
              state <= STOP;
            end else begin
              sh[bit_cnt] <= rxs;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          STOP: if (last) begin
            cnt <= '0;
            stop_bad <= !rxs;
            bit_cnt <= 4'd1;
            if (commit) state <= IDLE;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: randomized frame stimulus checked against a frame-level reference model
module tb_receiver;
  logic baud_clock = 0, reset = 1, serial_data_in = 1, MCR1 = 1, data_ack = 0;
  logic [3:0] data_length = 4'd9;
  logic [1:0] num_stop_bit = 2'b00;
  logic [8:0] data_out;
  logic rx_valid, framing_error, overrun_error, n_RTS;
  int vectors = 0, errors = 0, cyc = 0, rise = -1;
  logic rv_prev = 0;
  logic exp_valid = 0, exp_fe = 0, exp_ovr = 0;
  logic [8:0] exp_word = '0;

  receiver dut (.baud_clock(baud_clock), .reset(reset), .serial_data_in(serial_data_in),
    .data_length(data_length), .num_stop_bit(num_stop_bit), .MCR1(MCR1), .data_ack(data_ack),
    .data_out(data_out), .rx_valid(rx_valid), .framing_error(framing_error),
    .overrun_error(overrun_error), .n_RTS(n_RTS));

  always #5 baud_clock = ~baud_clock;
  always @(posedge baud_clock) cyc <= cyc + 1;
  // records the index of the edge on which rx_valid rose
  always @(posedge baud_clock) begin
    #1;
    if (rx_valid && !rv_prev) rise = cyc - 1;
    rv_prev = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge baud_clock);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data_out"}, 32'(data_out), 32'(exp_word));
    check({tag, ".rx_valid"}, 32'(rx_valid), 32'(exp_valid));
    check({tag, ".framing_error"}, 32'(framing_error), 32'(exp_fe));
    check({tag, ".overrun_error"}, 32'(overrun_error), 32'(exp_ovr));
    check({tag, ".n_RTS"}, 32'(n_RTS), 32'(!(MCR1 && !exp_valid)));
  endtask

  task automatic send(input string tag, input logic [8:0] w, input logic [3:0] len,
                      input logic [1:0] nsb, input logic s1, input logic s2);
    int nb, e0;
    logic free;
    logic [8:0] mask;
    nb = (len >= 6 && len <= 9) ? int'(len) : 9;
    data_length = len;
    num_stop_bit = nsb;
    @(negedge baud_clock);
    free = !exp_valid;
    e0 = cyc;
    serial_data_in = 0;
    tick(16);
    for (int k = 0; k < nb; k++) begin
      serial_data_in = (k == nb - 1) ? w[8] : w[k];
      tick(16);
    end
    serial_data_in = s1;
    tick(16);
    if (nsb[1]) begin
      serial_data_in = s2;
      tick(nsb[0] ? 16 : 8);
    end
    serial_data_in = 1;
    tick(4);
    mask = 9'h100 | ((9'h1 << (nb - 1)) - 9'h1);
    if (free) begin
      exp_valid = 1;
      exp_word = w & mask;
      exp_fe = !s1 || (nsb == 2'b11 && !s2);
      check({tag, ".latency"}, 32'(rise - e0), 32'(26 + 16 * nb + (nsb == 2'b11 ? 16 : 0)));
    end else exp_ovr = 1;
    check_outputs(tag);
  endtask

  task automatic ack(input string tag);
    @(negedge baud_clock);
    data_ack = 1;
    @(negedge baud_clock);
    data_ack = 0;
    exp_valid = 0;
    exp_ovr = 0;
    check_outputs(tag);
  endtask

  task automatic glitch(input int k);
    @(negedge baud_clock);
    serial_data_in = 0;
    tick(k);
    serial_data_in = 1;
    tick(30);
    check_outputs("glitch");
  endtask

  task automatic do_reset();
    @(negedge baud_clock);
    reset = 0;
    #1;
    exp_valid = 0;
    exp_fe = 0;
    exp_ovr = 0;
    exp_word = '0;
    check("reset.data_out", 32'(data_out), 32'h0);
    check("reset.rx_valid", 32'(rx_valid), 32'h0);
    check("reset.framing_error", 32'(framing_error), 32'h0);
    check("reset.overrun_error", 32'(overrun_error), 32'h0);
    check("reset.n_RTS", 32'(n_RTS), 32'h1);
    tick(3);
    serial_data_in = 1;
    reset = 1;
    tick(4);
  endtask

  initial begin
    #2 reset = 0;
    tick(2);
    reset = 1;
    tick(4);
    check_outputs("init");
    send("f1a5", 9'h1A5, 4'd9, 2'b00, 1, 1);
    ack("ack1");
    send("f10d", 9'h10D, 4'd6, 2'b00, 1, 1);
    ack("ack2");
    glitch(8);
    send("stop_bad", 9'h0F3, 4'd8, 2'b00, 0, 1);
    ack("ack3");
    send("stop2_bad", 9'h15A, 4'd8, 2'b11, 1, 0);
    ack("ack4");
    send("ovr_a", 9'h033, 4'd8, 2'b00, 1, 1);
    send("ovr_b", 9'h1CC, 4'd8, 2'b00, 1, 1);
    ack("ack5");
    data_length = 4'd8;
    @(negedge baud_clock);
    serial_data_in = 0;
    tick(16 * 5);
    do_reset();
    send("after_reset", 9'h1E7, 4'd8, 2'b01, 1, 1);
    ack("ack6");
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) ack("rnd_ack");
      if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, 8));
      send("rnd", 9'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
